// File: rtl/encoder_16to4_arb_pkg.sv
// Shared constants, state type and bit helpers for the 16-to-4 request encoder.
package encoder_16to4_arb_pkg;

  localparam int ENC_N = 16;
  localparam int ENC_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } enc_state_t;

  function automatic logic [ENC_N-1:0] enc_onehot(input logic [ENC_W-1:0] idx);
    logic [ENC_N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [ENC_N-1:0] enc_bitrev(input logic [ENC_N-1:0] vec);
    logic [ENC_N-1:0] v;
    for (int i = 0; i < ENC_N; i++) begin
      v[i] = vec[ENC_N-1-i];
    end
    return v;
  endfunction

endpackage

// File: rtl/encoder_16to4_arb_prio_enc16.sv
// Combinational find-first-set over 16 bits, scanning upward from 'start' and
// wrapping 15 -> 0.
module prio_enc16
  import encoder_16to4_arb_pkg::*;
(
  input  logic [ENC_N-1:0] vec,
  input  logic [ENC_W-1:0] start,
  output logic [ENC_W-1:0] idx,
  output logic             found
);

  logic [ENC_N-1:0] w_rot;
  logic [ENC_W-1:0] w_off;

  // Rotate so that bit 0 of w_rot is vec[start]; the 4-bit add wraps naturally.
  generate
    for (genvar gi = 0; gi < ENC_N; gi++) begin : g_rot
      logic [ENC_W-1:0] w_sel;
      assign w_sel     = start + ENC_W'(gi);
      assign w_rot[gi] = vec[w_sel];
    end
  endgenerate

  always_comb begin
    w_off = '0;
    found = 1'b0;
    for (int i = ENC_N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = ENC_W'(i);
        found = 1'b1;
      end
    end
  end

  assign idx = start + w_off;

endmodule

// File: rtl/encoder_16to4_arb.sv
// Sticky 16-line request capture with fixed-priority or round-robin arbitration,
// presenting the winner as a 4-bit code on a valid/ready handshake.
module encoder_16to4_arb
  import encoder_16to4_arb_pkg::*;
#(
  parameter int unsigned RR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ENC_N-1:0] req,
  input  logic             enable,
  input  logic             clr,
  output logic [ENC_W-1:0] code,
  output logic             valid,
  input  logic             ready,
  output logic [ENC_N-1:0] pending,
  output logic             any_pending
);

  localparam bit RR_EN = (RR != 0);

  enc_state_t       r_state;
  enc_state_t       w_state_next;
  logic [ENC_W-1:0] r_code;
  logic [ENC_W-1:0] w_code_next;
  logic [ENC_W-1:0] r_last_grant;
  logic [ENC_N-1:0] r_pending;
  logic [ENC_N-1:0] w_pend_next;

  logic             w_valid;
  logic             w_accept;
  logic [ENC_N-1:0] w_cand;
  logic [ENC_W-1:0] w_last;
  logic [ENC_N-1:0] w_vec;
  logic [ENC_W-1:0] w_start;
  logic [ENC_W-1:0] w_idx;
  logic             w_found;
  logic [ENC_W-1:0] w_winner;

  assign w_valid  = (r_state == HOLD);
  assign w_accept = w_valid & ready;

  // Candidates never include same-cycle req; on accept the served bit is excluded
  // and the round-robin origin moves to the code being served right now.
  assign w_cand = w_accept ? (r_pending & ~enc_onehot(r_code)) : r_pending;
  assign w_last = w_accept ? r_code : r_last_grant;

  // Fixed priority reuses the upward scanner on the bit-reversed vector.
  assign w_vec    = RR_EN ? w_cand : enc_bitrev(w_cand);
  assign w_start  = RR_EN ? (w_last + 1'b1) : '0;
  assign w_winner = RR_EN ? w_idx : (ENC_W'(ENC_N - 1) - w_idx);

  prio_enc16 u_prio_enc16 (
    .vec   (w_vec),
    .start (w_start),
    .idx   (w_idx),
    .found (w_found)
  );

  // Set wins over an accept-clear on the same bit; clr overrides everything.
  generate
    for (genvar gi = 0; gi < ENC_N; gi++) begin : g_pend
      assign w_pend_next[gi] = !clr &&
                               ((enable && req[gi]) ||
                                (r_pending[gi] && !(w_accept && (r_code == ENC_W'(gi)))));
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    if (clr) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable && w_found) begin
            w_state_next = HOLD;
            w_code_next  = w_winner;
          end
        end
        HOLD: begin
          if (w_accept) begin
            if (enable && w_found) begin
              w_code_next = w_winner;
            end else begin
              w_state_next = IDLE;
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_code       <= '0;
      r_last_grant <= '1;
      r_pending    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_code    <= w_code_next;
      r_pending <= w_pend_next;
      if (w_accept && !clr) begin
        r_last_grant <= r_code;
      end
    end
  end

  assign code        = r_code;
  assign valid       = w_valid;
  assign pending     = r_pending;
  assign any_pending = |r_pending;

endmodule

// File: tb/tb_encoder_16to4_arb.sv
// Directed bench: one fixed-priority and one round-robin instance, driven in turn.
module tb_encoder_16to4_arb;

  logic        clk;
  logic        rst_n;

  logic [15:0] f_req, r_req;
  logic        f_en, r_en, f_clr, r_clr, f_rdy, r_rdy;
  logic [3:0]  f_code, r_code;
  logic        f_valid, r_valid, f_any, r_any;
  logic [15:0] f_pend, r_pend;

  int n_total;
  int n_bad;

  encoder_16to4_arb #(.RR(0)) u_fp (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (f_req),
    .enable      (f_en),
    .clr         (f_clr),
    .code        (f_code),
    .valid       (f_valid),
    .ready       (f_rdy),
    .pending     (f_pend),
    .any_pending (f_any)
  );

  encoder_16to4_arb #(.RR(1)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (r_req),
    .enable      (r_en),
    .clr         (r_clr),
    .code        (r_code),
    .valid       (r_valid),
    .ready       (r_rdy),
    .pending     (r_pend),
    .any_pending (r_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_fp[4];

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0;
    f_req = '0; f_en = 1'b0; f_clr = 1'b0; f_rdy = 1'b0;
    r_req = '0; r_en = 1'b0; r_clr = 1'b0; r_rdy = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", 32'(f_valid), 32'd0);
    check_eq("rst_code", 32'(f_code), 32'd0);
    check_eq("rst_pend", 32'(f_pend), 32'd0);
    check_eq("rst_any", 32'(f_any), 32'd0);
    rst_n = 1'b1;

    // Async reset mid-handshake
    f_en = 1'b1; f_rdy = 1'b0; f_req = 16'h0004;
    tick();
    f_req = '0;
    tick();
    check_eq("ar_pre_valid", 32'(f_valid), 32'd1);
    check_eq("ar_pre_code", 32'(f_code), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_valid", 32'(f_valid), 32'd0);
    check_eq("ar_code", 32'(f_code), 32'd0);
    check_eq("ar_pend", 32'(f_pend), 32'd0);
    tick();
    rst_n = 1'b1;
    f_rdy = 1'b1;
    tick();
    tick();
    check_eq("idle_valid", 32'(f_valid), 32'd0);
    check_eq("idle_pend", 32'(f_pend), 32'd0);

    // Fixed priority drain of 16'h8421
    exp_fp = '{15, 10, 5, 0};
    f_req = 16'h8421;
    tick();
    f_req = '0;
    check_eq("fp_pend", 32'(f_pend), 32'h8421);
    check_eq("fp_lat_valid", 32'(f_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("fp_valid%0d", k), 32'(f_valid), 32'd1);
      check_eq($sformatf("fp_code%0d", k), 32'(f_code), 32'(exp_fp[k]));
    end
    tick();
    check_eq("fp_end_valid", 32'(f_valid), 32'd0);
    check_eq("fp_end_pend", 32'(f_pend), 32'd0);
    check_eq("fp_end_any", 32'(f_any), 32'd0);

    // Hold stability against a higher-priority arrival
    f_rdy = 1'b0; f_req = 16'h0010;
    tick();
    f_req = '0;
    tick();
    check_eq("hold_code0", 32'(f_code), 32'd4);
    f_req = 16'h8000;
    tick();
    f_req = '0;
    check_eq("hold_pend", 32'(f_pend), 32'h8010);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("hold_code%0d", k + 1), 32'(f_code), 32'd4);
      check_eq($sformatf("hold_valid%0d", k + 1), 32'(f_valid), 32'd1);
      tick();
    end
    f_rdy = 1'b1;
    tick();
    check_eq("hold_next_code", 32'(f_code), 32'd15);
    check_eq("hold_next_valid", 32'(f_valid), 32'd1);
    tick();
    check_eq("hold_end_valid", 32'(f_valid), 32'd0);

    // Set wins over accept-clear on the same bit
    f_rdy = 1'b0; f_req = 16'h0080;
    tick();
    f_req = '0;
    tick();
    check_eq("sw_code", 32'(f_code), 32'd7);
    f_rdy = 1'b1; f_req = 16'h0080;
    tick();
    f_req = '0;
    check_eq("sw_pend", 32'(f_pend), 32'h0080);
    check_eq("sw_gap_valid", 32'(f_valid), 32'd0);
    tick();
    check_eq("sw_regrant_valid", 32'(f_valid), 32'd1);
    check_eq("sw_regrant_code", 32'(f_code), 32'd7);
    tick();
    check_eq("sw_end_valid", 32'(f_valid), 32'd0);
    check_eq("sw_end_pend", 32'(f_pend), 32'd0);

    // enable=0 ignores req
    f_en = 1'b0; f_req = 16'h00FF;
    tick();
    tick();
    check_eq("en0_pend", 32'(f_pend), 32'd0);
    check_eq("en0_valid", 32'(f_valid), 32'd0);

    // clr overrides capture and drops valid
    f_en = 1'b1; f_rdy = 1'b0; f_req = 16'h0030;
    tick();
    f_req = '0;
    tick();
    check_eq("clr_pre_code", 32'(f_code), 32'd5);
    check_eq("clr_pre_pend", 32'(f_pend), 32'h0030);
    f_clr = 1'b1; f_req = 16'h0001;
    tick();
    f_clr = 1'b0; f_req = '0;
    check_eq("clr_pend", 32'(f_pend), 32'd0);
    check_eq("clr_valid", 32'(f_valid), 32'd0);
    tick();
    check_eq("clr_after_valid", 32'(f_valid), 32'd0);
    f_en = 1'b0;

    // Round-robin over all 16 lines, first search from 0
    r_en = 1'b1; r_rdy = 1'b1; r_req = 16'hFFFF;
    tick();
    r_req = '0;
    check_eq("rr_pend", 32'(r_pend), 32'hFFFF);
    for (int k = 0; k < 16; k++) begin
      tick();
      check_eq($sformatf("rr_code%0d", k), 32'(r_code), 32'(k));
    end
    tick();
    check_eq("rr_end_valid", 32'(r_valid), 32'd0);
    check_eq("rr_end_pend", 32'(r_pend), 32'd0);

    // Persistent req[3] and req[9] alternate
    r_req = 16'h0208;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("rr_alt%0d", k), 32'(r_code), (k % 2 == 0) ? 32'd3 : 32'd9);
      check_eq($sformatf("rr_alt_pend%0d", k), 32'(r_pend), 32'h0208);
    end
    r_req = '0;
    tick();
    check_eq("rr_drain_code", 32'(r_code), 32'd3);
    tick();
    check_eq("rr_drain_valid", 32'(r_valid), 32'd0);
    check_eq("rr_drain_pend", 32'(r_pend), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
